// File: rtl/cella_acc_pkg.sv
// rtl/cella_acc_pkg.sv - shared types and width helpers for the bit-serial shift accumulator
package cella_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Result width: one extra bit per plane shift keeps the full range without saturation
    function automatic int calc_out_w(input int in_w, input int nbits);
        return in_w + nbits;
    endfunction

endpackage

// File: rtl/shift_accumulator.sv
// rtl/shift_accumulator.sv - MSB-first bit-plane shift-and-add accumulator with valid/ready handshake
module shift_accumulator
    import cella_acc_pkg::*;
#(
    parameter int IN_W       = 12,
    parameter int NBITS      = 8,
    parameter int SIGNED_ACT = 1,
    localparam int OUT_W     = calc_out_w(IN_W, NBITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    // A single-plane configuration still needs a one-bit counter
    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    acc_state_t       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [OUT_W-1:0] in_ext;
    logic [OUT_W-1:0] acc_calc;
    logic             beat;

    assign in_ready  = (state_q == ACC);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state, accumulate step and result capture; clear overrides everything
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        beat   = (state_q == ACC) && in_valid;
        in_ext = OUT_W'(in_data);
        // The first (MSB) plane of a signed activation carries weight -2^(NBITS-1)
        if ((SIGNED_ACT != 0) && (cnt_q == '0)) begin
            acc_calc = '0 - in_ext;
        end else begin
            acc_calc = (acc_q << 1) + in_ext;
        end

        if (clear) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = acc_calc;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            out_data_d  = acc_calc;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (start) begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ACC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // All architectural state registered here, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_shift_accumulator.sv
// tb/tb_shift_accumulator.sv - self-checking bench for shift_accumulator (unsigned and signed instances)
module tb_shift_accumulator;

    typedef logic [7:0][11:0] beats_t;

    typedef struct {
        beats_t      beats;
        logic [19:0] exp_u;
        logic [19:0] exp_s;
    } vec_t;

    typedef struct {
        logic [19:0] u;
        logic [19:0] s;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready_u, out_valid_u, busy_u;
    logic [19:0] out_data_u;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [19:0] out_data_s;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];
    vec_t tbl[8];

    shift_accumulator #(.IN_W(12), .NBITS(8), .SIGNED_ACT(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_u),
        .out_valid(out_valid_u), .out_data(out_data_u), .out_ready(out_ready),
        .busy(busy_u)
    );

    shift_accumulator #(.IN_W(12), .NBITS(8), .SIGNED_ACT(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
        .busy(busy_s)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] model(input beats_t b, input bit sgn);
        longint s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            longint v;
            v = longint'(b[i]);
            if (sgn && i == 0) v = -v;
            s = s + v * (longint'(1) << (7 - i));
        end
        return s[19:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [11:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready_u) break;
            @(posedge clk);
        end
        if (k == 20) timeout_fail("beat_accept");
        tick();
        in_valid = 1'b0;
        in_data  = 12'($urandom);
    endtask

    // Sends eight beats with optional idle gaps; the expectation is queued before the final beat
    task automatic send8(input beats_t b, input logic [19:0] eu, input logic [19:0] es, input int gap);
        res_t r;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                r.u = eu;
                r.s = es;
                sb.push_back(r);
            end
            send_beat(b[i]);
            if (i != 7) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic wait_empty();
        int k;
        for (k = 0; k < 100 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            timeout_fail("result_drain");
            sb.delete();
        end
    endtask

    // Scoreboard: a result leaves the DUT when out_valid meets out_ready
    always @(negedge clk) begin
        if (!rst && out_valid_u && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", out_data_u);
            end else begin
                res_t r;
                r = sb.pop_front();
                chk("result_unsigned", out_data_u, r.u);
                chk("result_signed", out_data_s, r.s);
                chk("signed_valid_align", out_valid_s, 1'b1);
            end
        end
    end

    initial begin
        beats_t bb;
        logic [19:0] held_u, held_s;

        bb = {8{12'd4080}};
        tbl[0] = '{bb, 20'hFE010, 20'hFF010};
        bb = '0; bb[0] = 12'd100;
        tbl[1] = '{bb, 20'h03200, 20'hFCE00};
        bb = {8{12'd1}}; bb[0] = 12'd0;
        tbl[2] = '{bb, 20'd127, 20'd127};
        bb = {8{12'd1}};
        tbl[3] = '{bb, 20'd255, 20'hFFFFF};
        for (int i = 4; i < 8; i++) begin
            for (int j = 0; j < 8; j++) bb[j] = 12'($urandom);
            tbl[i] = '{bb, model(bb, 1'b0), model(bb, 1'b1)};
        end

        // Reset state
        #2;
        chk("rst_busy", busy_u, 1'b0);
        chk("rst_in_ready", in_ready_u, 1'b0);
        chk("rst_out_valid", out_valid_u, 1'b0);
        chk("rst_out_data", out_data_s, 20'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table vectors, back-to-back beats, result one cycle after the final beat
        for (int i = 0; i < 8; i++) begin
            start_op();
            send8(tbl[i].beats, tbl[i].exp_u, tbl[i].exp_s, 0);
            chk("latency_valid", out_valid_u, 1'b1);
            wait_empty();
        end

        // in_data offered while idle must be ignored
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        tick();
        chk("idle_in_ready", in_ready_u, 1'b0);
        tick();
        in_valid = 1'b0;

        // Gaps between beats and a stalled consumer with a stray start
        out_ready = 1'b0;
        start_op();
        send8(tbl[0].beats, tbl[0].exp_u, tbl[0].exp_s, 2);
        held_u = tbl[0].exp_u;
        held_s = tbl[0].exp_s;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start = 1'b1;
            @(negedge clk);
            chk("stall_valid", out_valid_u, 1'b1);
            chk("stall_data_u", out_data_u, held_u);
            chk("stall_data_s", out_data_s, held_s);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        wait_empty();
        chk("stall_back_idle", busy_u, 1'b0);
        chk("stall_valid_drop", out_valid_u, 1'b0);

        // Clear mid-accumulation wins over start and in_valid
        start_op();
        for (int i = 0; i < 3; i++) send_beat(12'hFFF);
        clear = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 12'hFFF;
        tick();
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("clear_busy", busy_u, 1'b0);
        chk("clear_valid", out_valid_s, 1'b0);
        start_op();
        send8(tbl[3].beats, 20'd255, 20'hFFFFF, 0);
        wait_empty();

        // Asynchronous reset between edges mid-accumulation
        start_op();
        for (int i = 0; i < 3; i++) send_beat(12'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy_u, 1'b0);
        chk("arst_in_ready", in_ready_s, 1'b0);
        chk("arst_out_data", out_data_u, 20'd0);
        chk("arst_out_valid", out_valid_u, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst_no_restart", in_ready_u, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // Back-to-back: release the result and start again in the same cycle
        start_op();
        send8(tbl[4].beats, tbl[4].exp_u, tbl[4].exp_s, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_in_ready", in_ready_u, 1'b1);
        send8(tbl[5].beats, tbl[5].exp_u, tbl[5].exp_s, 0);
        wait_empty();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
